// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-port arbiter.
// Contents:
//   MEM_TYPE_READ / MEM_TYPE_WRITE   message type encodings
//   mem_req_t / mem_resp_t           memory message layouts (MEM_NBITS data)
//   id_width()                       bits needed to hold a requester index
package mem_port_pkg;

    localparam int MEM_NBITS     = 32;
    localparam int MEM_ADDR_BITS = 32;

    localparam logic MEM_TYPE_READ  = 1'b0;
    localparam logic MEM_TYPE_WRITE = 1'b1;

    // 'type' is a keyword, so the type field is called mtype.
    typedef struct packed {
        logic                     mtype;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_NBITS-1:0]     data;
    } mem_req_t;

    typedef struct packed {
        logic                 mtype;
        logic [MEM_NBITS-1:0] data;
    } mem_resp_t;

    // Never return zero so a single-requester build still has a legal vector.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Requester-ID FIFO: remembers which requester issued each outstanding
// memory request so responses can be routed back in order.
// Ports:
//   clk, reset   clock, synchronous active-high reset (drops all entries)
//   push, push_id  enqueue push_id
//   pop            dequeue the head entry
//   full, empty    occupancy flags
//   head           ID at the head of the queue (valid when !empty)
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[rptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) slots[wptr] <= push_id;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between NREQS requesters. Requests are granted
// round-robin; responses come back in issue order and are steered to the
// requester recorded at the head of the ID FIFO. No pipeline registers:
// both directions are combinational pass-through.
// Handshake: a transfer happens on a cycle where both val and rdy are high;
// val never depends on the matching rdy.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req_val/req_rdy                   per-requester request handshake
//   req_type/req_addr/req_data        packed per-requester request fields
//   resp_val/resp_rdy                 per-requester response handshake
//   resp_type/resp_data               broadcast response fields
//   mem_req_*                         request channel to memory
//   mem_resp_*                        response channel from memory
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int nbits  = 32,
    parameter int NREQS  = 2,
    parameter int MAXOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQS-1:0]       req_val,
    output logic [NREQS-1:0]       req_rdy,
    input  logic [NREQS-1:0]       req_type,
    input  logic [NREQS*32-1:0]    req_addr,
    input  logic [NREQS*nbits-1:0] req_data,
    output logic [NREQS-1:0]       resp_val,
    input  logic [NREQS-1:0]       resp_rdy,
    output logic                   resp_type,
    output logic [nbits-1:0]       resp_data,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic                   mem_req_type,
    output logic [31:0]            mem_req_addr,
    output logic [nbits-1:0]       mem_req_data,
    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  logic                   mem_resp_type,
    input  logic [nbits-1:0]       mem_resp_data
);

    localparam int IDW = id_width(NREQS);

    logic [IDW-1:0]   prio_ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   head;
    logic [NREQS-1:0] grant;
    logic             grant_any;
    logic             full;
    logic             empty;
    logic             req_fire;
    logic             resp_fire;

    // Round-robin scan starting at prio_ptr; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NREQS; k++) begin
            idx = (int'(prio_ptr) + k) % NREQS;
            if (!grant_any && req_val[idx]) begin
                grant_any  = 1'b1;
                grant_id   = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // A full FIFO blocks issue even when a pop lands in the same cycle,
    // which keeps full free of any path from the response side.
    assign mem_req_val = grant_any && !full;
    assign req_rdy     = grant & {NREQS{mem_req_rdy && !full}};
    assign req_fire    = mem_req_val && mem_req_rdy;

    always_comb begin
        mem_req_type = MEM_TYPE_READ;
        mem_req_addr = '0;
        mem_req_data = '0;
        if (grant_any) begin
            mem_req_type = req_type[grant_id];
            mem_req_addr = req_addr[int'(grant_id)*32 +: 32];
            mem_req_data = req_data[int'(grant_id)*nbits +: nbits];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)         prio_ptr <= '0;
        else if (req_fire) prio_ptr <= IDW'((int'(grant_id) + 1) % NREQS);
    end

    // Responses only route while an ID is outstanding, so anything arriving
    // after a reset is left unconsumed.
    always_comb begin
        resp_val = '0;
        if (mem_resp_val && !empty) resp_val[head] = 1'b1;
    end

    assign mem_resp_rdy = !empty && resp_rdy[head];
    assign resp_fire    = mem_resp_val && mem_resp_rdy;
    assign resp_type    = mem_resp_type;
    assign resp_data    = mem_resp_data;

    arb_id_fifo #(
        .DEPTH (MAXOUT),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (req_fire),
        .push_id (grant_id),
        .pop     (resp_fire),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

endmodule
